// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a word-wide data memory.
// Byte and half stores use read-modify-write; loads are sign- or zero-extended.
module load_store_unit #(
    parameter logic [31:0] DATA_BASE = 32'h02000000,
    parameter int          MEM_SIZE  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wr_en,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    input  logic [31:0] mem_rd_data
);

    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;

    // 33-bit bound so a window ending at the top of the address space cannot wrap
    localparam logic [32:0] RANGE_END = {1'b0, DATA_BASE} + 33'(4 * MEM_SIZE);

    state_t      state;
    state_t      state_next;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        err_q;

    logic        accept;
    logic        req_err;
    logic        misaligned;
    logic        in_range;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;
    logic [31:0] merged;

    assign accept = req_valid && (state == IDLE);

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = (req_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        in_range = ({1'b0, req_addr} >= {1'b0, DATA_BASE}) && ({1'b0, req_addr} < RANGE_END);
        req_err  = misaligned || !in_range;
    end

    always_comb begin
        byte_lane = mem_rd_data[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
        load_data = mem_rd_data;
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_data = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default: load_data = mem_rd_data;
        endcase
        // Untouched lanes come straight from the word just read
        merged = mem_rd_data;
        if (size_q == 2'b00) begin
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q     <= req_addr;
                wdata_q    <= req_wdata;
                rdata_q    <= '0;
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                err_q      <= req_err;
            end else if (state == LOAD) begin
                rdata_q <= load_data;
            end else if (state == RMW_RD) begin
                wdata_q <= merged;
            end
        end
    end

    always_comb begin
        state_next  = state;
        req_ready   = (state == IDLE);
        resp_valid  = (state == RESP);
        resp_rdata  = '0;
        resp_err    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)                state_next = RESP;
                    else if (!req_we)           state_next = LOAD;
                    else if (req_size == 2'b10) state_next = WRITE;
                    else                        state_next = RMW_RD;
                end
            end
            LOAD: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = RESP;
            end
            RMW_RD: begin
                mem_addr   = {addr_q[31:2], 2'b00};
                state_next = WRITE;
            end
            WRITE: begin
                mem_wr_en   = 1'b1;
                mem_addr    = {addr_q[31:2], 2'b00};
                mem_wr_data = wdata_q;
                state_next  = RESP;
            end
            RESP: begin
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word-array memory model plus a byte-lane reference
// model that predicts response data, error flag, latency and memory contents.
module tb_load_store_unit;

    localparam logic [31:0] BASE  = 32'h02000000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] LIMIT = BASE + 32'd256;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wr_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic [31:0] mem_rd_data;

    logic [31:0] mem      [DEPTH];
    logic [31:0] init_mem [DEPTH];
    logic [31:0] ref_mem  [DEPTH];
    logic        init_req;
    logic [31:0] rd_off;
    logic [31:0] wr_off;
    logic [31:0] last_rdata;

    int check_count;
    int pass_count;

    load_store_unit #(.DATA_BASE(BASE), .MEM_SIZE(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_off = mem_addr - BASE;
    assign wr_off = mem_addr - BASE;

    always_comb begin
        mem_rd_data = '0;
        if (mem_addr >= BASE && mem_addr < LIMIT) mem_rd_data = mem[rd_off[7:2]];
    end

    // Synchronous-write data memory, preloaded once while the DUT is in reset
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_mem[i];
        end else if (mem_wr_en && mem_addr >= BASE && mem_addr < LIMIT) begin
            mem[wr_off[7:2]] <= mem_wr_data;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) pass_count++;
        else $display("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, observed, expected);
    endtask

    // Entered and left on a falling edge with the unit idle
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input logic [31:0] addr, input logic [31:0] wdata, input logic hold_busy);
        logic        exp_err;
        logic [31:0] exp_rdata, word, lane, off, wr_addr, busy_addr;
        int          exp_lat, exp_writes, idx, sh, cycles, writes;
        logic        got;

        off       = addr - BASE;
        idx       = int'(off[7:2]);
        sh        = 8 * int'(addr % 4);
        exp_err   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
                    (size == 2'd2 && (addr % 4) != 0) || addr < BASE || addr >= LIMIT;
        word      = ref_mem[idx];
        exp_rdata = '0;
        exp_writes = 0;
        if (exp_err) begin
            exp_lat = 1;
        end else if (!we) begin
            exp_lat = 2;
            if (size == 2'd0) begin
                lane = (word >> sh) & 32'hFF;
                if (!uns && lane >= 32'd128) lane = lane | 32'hFFFFFF00;
                exp_rdata = lane;
            end else if (size == 2'd1) begin
                lane = (word >> sh) & 32'hFFFF;
                if (!uns && lane >= 32'd32768) lane = lane | 32'hFFFF0000;
                exp_rdata = lane;
            end else begin
                exp_rdata = word;
            end
        end else begin
            exp_writes = 1;
            exp_lat    = (size == 2'd2) ? 2 : 3;
            if (size == 2'd0)      word = (word & ~(32'hFF << sh)) | ((wdata & 32'hFF) << sh);
            else if (size == 2'd1) word = (word & ~(32'hFFFF << sh)) | ((wdata & 32'hFFFF) << sh);
            else                   word = wdata;
            ref_mem[idx] = word;
        end

        checkOutput("ready_before", {31'b0, req_ready}, 32'd1);
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        busy_addr    = BASE + ($urandom_range(0, 63) << 2);
        req_valid    = hold_busy;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = $urandom_range(0, 1) == 1;
        req_addr     = busy_addr;
        req_wdata    = $urandom;

        got = 1'b0; cycles = 0; writes = 0; wr_addr = '0;
        while (!got && cycles < 8) begin
            @(negedge clk);
            cycles++;
            if (mem_wr_en) begin
                writes++;
                wr_addr = mem_addr;
            end
            if (resp_valid) got = 1'b1;
            else checkOutput("ready_busy", {31'b0, req_ready}, 32'd0);
        end
        checkOutput("resp_latency", got ? cycles : 99, exp_lat);
        checkOutput("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
        checkOutput("resp_rdata", resp_rdata, exp_rdata);
        checkOutput("ready_in_resp", {31'b0, req_ready}, 32'd0);
        last_rdata = resp_rdata;
        req_valid  = 1'b0;
        checkOutput("write_count", writes, exp_writes);
        if (exp_writes == 1) checkOutput("write_addr", wr_addr, addr & 32'hFFFFFFFC);
        if (!exp_err) checkOutput("mem_word", mem[idx], ref_mem[idx]);
        @(negedge clk);
        checkOutput("ready_after", {31'b0, req_ready}, 32'd1);
        checkOutput("resp_single", {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        logic [1:0]  size;
        logic [31:0] addr;
        int          r;

        check_count = 0; pass_count = 0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; last_rdata = '0;
        for (int i = 0; i < DEPTH; i++) init_mem[i] = $urandom;
        init_mem[8]  = 32'h11223344;
        init_mem[12] = 32'h00000000;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_mem[i];
        init_req = 1'b1;
        @(posedge clk);
        #1 init_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'd0);
        checkOutput("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_wr_data", mem_wr_data, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 2'd2, 1'b0, 32'h02000010, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h02000010, 32'h0, 1'b0);
        checkOutput("plan_lw", last_rdata, 32'hDEADBEEF);

        applyStimulus(1'b1, 2'd0, 1'b0, 32'h02000022, 32'h123456AA, 1'b0);
        checkOutput("plan_sb_word", mem[8], 32'h11AA3344);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h02000022, 32'h0, 1'b0);
        checkOutput("plan_lb", last_rdata, 32'hFFFFFFAA);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h02000022, 32'h0, 1'b0);
        checkOutput("plan_lbu", last_rdata, 32'h000000AA);

        applyStimulus(1'b1, 2'd1, 1'b0, 32'h02000032, 32'h00008001, 1'b0);
        checkOutput("plan_sh_word", mem[12], 32'h80010000);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h02000032, 32'h0, 1'b0);
        checkOutput("plan_lh", last_rdata, 32'hFFFF8001);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h02000032, 32'h0, 1'b0);
        checkOutput("plan_lhu", last_rdata, 32'h00008001);

        applyStimulus(1'b0, 2'd2, 1'b0, 32'h02000002, 32'h0, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h01FFFFFC, 32'hCAFEF00D, 1'b0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h02000100, 32'hCAFEF00D, 1'b0);

        // Abandon a byte store while it is reading the old word
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h02000021; req_wdata = 32'h00000055; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rmw_rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
        checkOutput("rmw_rst_mem_addr", mem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rmw_rst_resp", {31'b0, resp_valid}, 32'd0);
            checkOutput("rmw_rst_wr_en_hold", {31'b0, mem_wr_en}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rmw_rst_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rmw_rst_resp_after", {31'b0, resp_valid}, 32'd0);
        checkOutput("rmw_rst_mem", mem[8], 32'h11AA3344);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h02000020, 32'h0, 1'b0);
        checkOutput("rmw_rst_lw", last_rdata, 32'h11AA3344);

        applyStimulus(1'b1, 2'd0, 1'b0, 32'h02000043, 32'h000000C3, 1'b1);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h02000044, 32'h13579BDF, 1'b1);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 7));
            size = (r == 0) ? 2'd3 : (r < 3) ? 2'd2 : (r < 5) ? 2'd1 : 2'd0;
            r = int'($urandom_range(0, 9));
            if (r == 0)      addr = BASE - 32'd4 * $urandom_range(1, 4);
            else if (r == 1) addr = LIMIT + $urandom_range(0, 7);
            else             addr = BASE + $urandom_range(0, 255);
            if (size == 2'd2 && $urandom_range(0, 3) != 0) addr = addr & 32'hFFFFFFFC;
            if (size == 2'd1 && $urandom_range(0, 3) != 0) addr = addr & 32'hFFFFFFFE;
            applyStimulus($urandom_range(0, 1) == 1, size, $urandom_range(0, 1) == 1,
                          addr, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access initiator for the RISC-V CPU data path. It accepts one load/store request at a time from the execute stage and drives the word-only data memory port, which has a combinational read and a synchronous write. Sub-word stores are built as a read-modify-write sequence, and loads are returned sign- or zero-extended. Misaligned or out-of-range requests return an error and never touch memory.

## Interface
Parameters:
- DATA_BASE, 32'h02000000, first byte address of data memory
- MEM_SIZE, 64, data memory depth in 32-bit words; valid range is DATA_BASE to DATA_BASE+4*MEM_SIZE-1

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu); ignored for stores and word loads
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the low bits are used for byte/half stores
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  qualified by resp_valid; misaligned or out-of-range request
- mem_wr_en  out  1  memory write enable
- mem_addr  out  32  word-aligned byte address; bits [1:0] always 00
- mem_wr_data  out  32  full word to write
- mem_rd_data  in  32  combinational read data for mem_addr

## Operation
- Requests are accepted on a rising edge with req_valid & req_ready. All request fields are registered at acceptance, so later input changes have no effect.
- An error is flagged when any of these holds:
  - req_size = 11
  - half access with addr[0] = 1
  - word access with addr[1:0] ≠ 00
  - addr outside the valid range
- States are IDLE, LOAD, RMW_RD, WRITE, RESP.
- From IDLE on acceptance:
  - error → RESP
  - load → LOAD
  - word store → WRITE
  - byte/half store → RMW_RD
- LOAD: drive mem_addr = {addr[31:2],2'b00} with mem_wr_en = 0. At the next edge, capture the extracted data and go to RESP.
  - Byte lane = addr[1:0]; half lane = addr[1], so bits [31:16] when addr[1] = 1. Ordering is little-endian.
  - Extension: signed replicates bit 7 or bit 15; unsigned fills with zeros.
- RMW_RD: drive mem_addr with mem_wr_en = 0. At the edge, merge the low byte/half of wdata into the selected lane of mem_rd_data, keep the other lanes, register the result, then go to WRITE.
- WRITE: mem_wr_en = 1, mem_addr = word address, mem_wr_data = merged word (or req_wdata for a word store). At the edge, go to RESP.
- RESP: resp_valid = 1 for exactly one cycle, then return to IDLE.
- There is no backpressure on the response; the consumer must take it in that cycle.
- Outside LOAD/RMW_RD/WRITE: mem_wr_en = 0, mem_addr = 0, mem_wr_data = 0.
- mem_wr_en is decoded from the state register only, never from a request input.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0, resp_err 0, mem_wr_en 0, mem_addr 0, mem_wr_data 0.
- Reset is asynchronous. Asserting rst_n mid-operation, including in WRITE, drops mem_wr_en in the same cycle and abandons the request with no response.
- Let A be the accept edge. Then resp_valid is high in the cycle after:
  - error: A
  - load or word store: A+1
  - byte/half store: A+2
- req_ready is low from A until the unit is back in IDLE, i.e. for the cycle after the RESP cycle. Back-to-back throughput is one request per 3, 3, or 4 cycles respectively, and 2 cycles for an error.
- A request presented while req_ready = 0 is not accepted and must be held by the requester.
- Exactly one mem_wr_en cycle per valid store, zero per load or error.

## Test plan
- **Word store then load.** sw 0xDEADBEEF @0x02000010, then lw @0x02000010. Required: one mem_wr_en pulse with mem_addr 0x02000010; lw returns resp_rdata 0xDEADBEEF with resp_err 0; each resp_valid arrives on the cycle timing above.
- **Byte store RMW.** Memory word @0x02000020 = 0x11223344; sb 0xAA @0x02000022. Required: the word becomes 0x11AA3344. Then lb @0x02000022 returns 0xFFFFFFAA, and lbu returns 0x000000AA.
- **Half access.** sh 0x8001 @0x02000032 onto word 0x00000000 gives 0x80010000. lh returns 0xFFFF8001; lhu returns 0x00008001.
- **Errors.**
  - lw @0x02000002: resp_err 1 one cycle after accept, resp_rdata 0, mem_wr_en never high.
  - sw @0x01FFFFFC: same result.
  - sw @0x02000100 with MEM_SIZE=64: same result.
- **Reset mid-RMW.** Assert rst_n low during the RMW_RD state of an sb. Required: memory is unchanged, no resp_valid, req_ready is 1 after release, and the next lw returns the old word.
- **Hold while busy.** Keep req_valid high with changing address during a store. Required: only the registered request executes; the new request is accepted only when req_ready = 1.
